// File: rtl/servo_pwm_core.sv
// Servo PWM frame generator: 1 us prescaled ticks, frame-boundary shadow loading,
// pulse clamping to the servo-safe range and per-frame slew limiting.
module servo_pwm_core #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int CNT_W       = 16,
    parameter int MIN_PULSE   = 500,
    parameter int MAX_PULSE   = 2500,
    parameter int DEF_PULSE   = 1500
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_us,
    input  logic [CNT_W-1:0] pulse_us,
    input  logic [CNT_W-1:0] slew_us,
    output logic             pwm_out,
    output logic             frame_start,
    output logic [CNT_W-1:0] cur_pulse,
    output logic             running
);

    localparam int DIV  = CLK_FREQ_HZ / 1_000_000;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(DIV - 1);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_PULSE);
    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(MAX_PULSE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PS_W-1:0]  presc, presc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] per_sh, per_nxt;
    logic [CNT_W-1:0] cur_nxt;
    logic             pwm_nxt, fs_nxt;

    logic             tick, frame_end;
    logic [CNT_W-1:0] per_load, tgt, cur_step;
    logic [CNT_W:0]   cur_x, tgt_x, slew_x;

    assign tick      = (presc == PS_LAST);
    assign frame_end = tick && (cnt == per_sh - CNT_W'(1));
    assign running   = (state != IDLE);

    // Values captured into the shadows at every frame boundary.
    assign per_load = (period_us < PER_MIN) ? PER_MIN : period_us;
    assign tgt      = (pulse_us < MIN_P) ? MIN_P :
                      (pulse_us > MAX_P) ? MAX_P : pulse_us;

    assign cur_x  = {1'b0, cur_pulse};
    assign tgt_x  = {1'b0, tgt};
    assign slew_x = {1'b0, slew_us};

    // One extra bit keeps cur+slew and tgt+slew from wrapping.
    always_comb begin
        cur_step = tgt;
        if (slew_us != '0) begin
            if (tgt_x > cur_x + slew_x)
                cur_step = cur_pulse + slew_us;
            else if (tgt_x + slew_x < cur_x)
                cur_step = cur_pulse - slew_us;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        cnt_nxt   = cnt;
        per_nxt   = per_sh;
        cur_nxt   = cur_pulse;
        fs_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                presc_nxt = '0;
                cnt_nxt   = '0;
                if (enable) begin
                    state_nxt = RUN;
                    per_nxt   = per_load;
                    cur_nxt   = cur_step;
                    fs_nxt    = 1'b1;
                end
            end
            RUN, STOP: begin
                presc_nxt = tick ? '0 : presc + PS_W'(1);
                state_nxt = enable ? RUN : STOP;
                if (frame_end) begin
                    cnt_nxt = '0;
                    if (enable) begin
                        per_nxt = per_load;
                        cur_nxt = cur_step;
                        fs_nxt  = 1'b1;
                    end else begin
                        // A falling enable at the boundary ends the run with no reload.
                        state_nxt = IDLE;
                    end
                end else if (tick) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Registered output computed from next-state values so the pulse rises with frame_start.
        pwm_nxt = (state_nxt != IDLE) && (cnt_nxt < cur_nxt);
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous and
    // takes priority over every update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            cnt         <= '0;
            per_sh      <= '0;
            cur_pulse   <= DEF_P;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            cnt         <= cnt_nxt;
            per_sh      <= per_nxt;
            cur_pulse   <= cur_nxt;
            pwm_out     <= pwm_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
